// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them into CPU instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 sum byte before the CPU is released.
module imem_loader #(
    parameter int MAX_WORDS   = 256,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] load_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);
    // state   | meaning
    // IDLE    | waiting for start, CPU held in reset
    // COLLECT | accepting the four bytes of the next word
    // WRITE   | driving one word into instruction memory for HOLD_CYCLES clocks
    // CHECK   | all words written; optional checksum byte
    // DONE    | load complete, CPU released
    // ERR     | load rejected, CPU held in reset
    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] words_q, words_d;
    logic [15:0] len_q, len_d;
    logic [3:0]  hold_q, hold_d;
    logic        len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign len_ok = (load_words != 16'd0) && ({1'b0, load_words} <= MAX_LEN);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_COLLECT) || (state_q == S_CHECK);
`else
    assign byte_ready = (state_q == S_COLLECT);
`endif
    assign initialize = (state_q == S_WRITE);
    assign cpu_rst    = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign instruction_initialize_data    = word_q;
    assign instruction_initialize_address = addr_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        len_d      = len_q;
        hold_d     = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d    = S_COLLECT;
                        addr_d     = 32'd0;
                        byte_cnt_d = 2'd0;
                        words_d    = 16'd0;
                        len_d      = load_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d      = 8'd0;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_COLLECT: begin
                if (byte_valid) begin
                    word_d     = {word_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        hold_d  = HOLD_LAST;
                    end
                end
            end
            S_WRITE: begin
                if (hold_q == 4'd0) begin
                    addr_d  = addr_q + 32'd4;
                    words_d = words_q + 16'd1;
                    state_d = (words_q + 16'd1 == len_q) ? S_CHECK : S_COLLECT;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (byte_valid) begin
                    state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            word_q     <= 32'd0;
            addr_q     <= 32'd0;
            byte_cnt_q <= 2'd0;
            words_q    <= 16'd0;
            len_q      <= 16'd0;
            hold_q     <= 4'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random programs are pushed in and the observed memory writes
// are compared with words built directly from the byte list (big-endian, address 4*i).
module tb_imem_loader;
    localparam int MAX_WORDS   = 256;
    localparam int HOLD_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] load_words = 16'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, initialize, cpu_rst, done, error;
    logic [31:0] instruction_initialize_data, instruction_initialize_address;

    imem_loader #(.MAX_WORDS(MAX_WORDS), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .load_words(load_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .initialize(initialize),
        .instruction_initialize_data(instruction_initialize_data),
        .instruction_initialize_address(instruction_initialize_address),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } wr_t;

    wr_t  wq[$];
    int   xfers = 0;
    int   unstable = 0;
    int   ready_in_write = 0;
    logic in_wr = 1'b0;
    wr_t  cur;

    // Observes every write burst: records address, data and how many clocks initialize stayed high.
    always @(negedge clk) begin
        if (!rst) begin
            in_wr = 1'b0;
        end else begin
            if (initialize) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    cur.addr = instruction_initialize_address;
                    cur.data = instruction_initialize_data;
                    cur.len = 1;
                end else begin
                    cur.len++;
                    if (instruction_initialize_address !== cur.addr || instruction_initialize_data !== cur.data)
                        unstable++;
                end
                if (byte_ready) ready_in_write++;
            end else if (in_wr) begin
                in_wr = 1'b0;
                wq.push_back(cur);
            end
            if (byte_valid && byte_ready) xfers++;
        end
    end

    function automatic logic [68:0] outs();
        return {byte_ready, initialize, cpu_rst, done, error,
                instruction_initialize_data, instruction_initialize_address};
    endfunction

    localparam logic [68:0] RESET_OUTS = {5'b00100, 64'd0};

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 100) begin
                checks++; errors++;
                $display("FAIL send_byte_timeout: byte_ready low for %0d cycles, expected 1", n);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start = 1'b1;
        load_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] prog[$], input int max_gap, input bit fixed_gap,
                           input logic [7:0] ck_delta, input bit poke, input string name);
        int n, base, x0, u0, r0, nb, g;
        logic [7:0] sum;
        bit exp_ok, fin;
        logic [31:0] w;
        n = prog.size() / 4;
        if (poke) begin
            byte_valid = 1'b1;
            byte_data = 8'hA5;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (byte_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_ready: got %b expected 0", name, byte_ready);
                end
                @(posedge clk); #1;
            end
            byte_valid = 1'b0;
        end
        base = wq.size(); x0 = xfers; u0 = unstable; r0 = ready_in_write;
        pulse_start(16'(n));
        @(negedge clk);
        checks++;
        if ({done, error, cpu_rst} !== 3'b001) begin
            errors++;
            $display("FAIL %s after_start: done/error/cpu_rst got %b expected 001", name, {done, error, cpu_rst});
        end
        @(posedge clk); #1;
        sum = 8'd0;
        nb = prog.size();
        for (int i = 0; i < prog.size(); i++) begin
            if (poke && i == 5) pulse_start(16'(n + 3));
            g = fixed_gap ? max_gap : int'($urandom_range(max_gap, 0));
            send_byte(prog[i], g);
            sum += prog[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum + ck_delta, 0);
        nb++;
        exp_ok = (ck_delta == 8'd0);
`else
        exp_ok = 1'b1;
`endif
        fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (done || error) fin = 1'b1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s finish_timeout: done=%b error=%b, expected one of them high", name, done, error);
        end
        checks++;
        if ({done, error, cpu_rst} !== (exp_ok ? 3'b100 : 3'b011)) begin
            errors++;
            $display("FAIL %s status: done/error/cpu_rst got %b expected %b", name,
                     {done, error, cpu_rst}, exp_ok ? 3'b100 : 3'b011);
        end
        checks++;
        if (instruction_initialize_address !== 32'(4 * n)) begin
            errors++;
            $display("FAIL %s final_addr: got %0h expected %0h", name, instruction_initialize_address, 4 * n);
        end
        checks++;
        if (wq.size() - base != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wq.size() - base, n);
        end
        for (int i = 0; i < n && i < wq.size() - base; i++) begin
            w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
            checks++;
            if (wq[base+i].addr !== 32'(4 * i) || wq[base+i].data !== w || wq[base+i].len != HOLD_CYCLES) begin
                errors++;
                $display("FAIL %s write%0d: got %0h@%0h x%0d expected %0h@%0h x%0d", name, i,
                         wq[base+i].data, wq[base+i].addr, wq[base+i].len, w, 4 * i, HOLD_CYCLES);
            end
        end
        checks++;
        if (xfers - x0 != nb) begin
            errors++;
            $display("FAIL %s byte_count: got %0d transfers expected %0d", name, xfers - x0, nb);
        end
        checks++;
        if (unstable != u0 || ready_in_write != r0) begin
            errors++;
            $display("FAIL %s write_phase: unstable=%0d ready_in_write=%0d expected 0 0", name,
                     unstable - u0, ready_in_write - r0);
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_prog(input int n, output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < 4 * n; i++) p.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", outs(), RESET_OUTS);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vector();
        logic [7:0] p[$];
        p = '{8'h00, 8'h02, 8'h08, 8'h20, 8'h00, 8'h02, 8'h08, 8'h20};
        do_load(p, 0, 1'b1, 8'd0, 1'b0, "vector_2words");
    endtask

    task automatic test_toggle();
        logic [7:0] p[$];
        p = '{8'h14, 8'h21, 8'hFF, 8'hFD};
        do_load(p, 1, 1'b1, 8'd0, 1'b0, "toggle_valid");
    endtask

    task automatic test_range_errors();
        int base;
        logic [15:0] bad[2];
        bad[0] = 16'd0;
        bad[1] = 16'(MAX_WORDS + 1);
        base = wq.size();
        for (int k = 0; k < 2; k++) begin
            pulse_start(bad[k]);
            checks++;
            if ({done, error, cpu_rst, initialize} !== 4'b0110) begin
                errors++;
                $display("FAIL range_err%0d: done/error/cpu_rst/init got %b expected 0110", k,
                         {done, error, cpu_rst, initialize});
            end
            repeat (3) @(posedge clk);
            #1;
        end
        checks++;
        if (wq.size() != base) begin
            errors++;
            $display("FAIL range_no_write: got %0d writes expected 0", wq.size() - base);
        end
    endtask

    task automatic test_random();
        logic [7:0] p[$];
        for (int k = 0; k < 6; k++) begin
            rand_prog(int'($urandom_range(8, 1)), p);
            do_load(p, 2, 1'b0, 8'd0, 1'b0, "random");
        end
    endtask

    task automatic test_ignore();
        logic [7:0] p[$];
        rand_prog(3, p);
        do_load(p, 1, 1'b0, 8'd0, 1'b1, "ignore_start_valid");
    endtask

    task automatic test_reset_midload();
        logic [7:0] p[$];
        pulse_start(16'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("FAIL reset_midload: got %h expected %h", outs(), RESET_OUTS);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rand_prog(1, p);
        do_load(p, 0, 1'b1, 8'd0, 1'b0, "after_reset_midload");
    endtask

    task automatic test_reset_midwrite();
        logic [7:0] p[$];
        bit seen;
        pulse_start(16'd2);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (initialize) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midwrite_no_init: initialize got 0 expected 1");
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("FAIL reset_midwrite: got %h expected %h", outs(), RESET_OUTS);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rand_prog(2, p);
        do_load(p, 1, 1'b0, 8'd0, 1'b0, "after_reset_midwrite");
    endtask

    task automatic test_max_len();
        logic [7:0] p[$];
        rand_prog(MAX_WORDS, p);
        do_load(p, 0, 1'b1, 8'd0, 1'b0, "max_words");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] p[$];
        p = '{8'h00, 8'h00, 8'h00, 8'h01};
        do_load(p, 0, 1'b1, 8'd0, 1'b0, "checksum_good");
        do_load(p, 0, 1'b1, 8'd1, 1'b0, "checksum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_vector();
        test_toggle();
        test_range_errors();
        test_random();
        test_ignore();
        test_reset_midload();
        test_reset_midwrite();
        test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
